// File: rtl/cpuif_host.sv
// cpuif_host
//   Single-outstanding initiator for the cpuif register interface. Takes one
//   command at a time from a valid/ready command stream and issues it as a
//   cpuif read or write request. It honours the responder's request stall,
//   waits for the matching ack, and applies a response timeout. The outcome
//   is returned on a valid/ready response stream.
//
// Ports
//   clk, reset_n            clock; synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_is_wr, cmd_addr     command type and register address
//   cmd_wr_data/_biten      write payload (ignored for reads)
//   rsp_valid/rsp_ready     response handshake
//   rsp_rd_data             read data (0 for writes, errors, timeouts)
//   rsp_err, rsp_timeout    responder error or timeout / timeout only
//   stray_ack               one-cycle pulse, ack with no matching request
//   cpuif_req*              registered request towards the responder
//   cpuif_req_stall_wr/rd   responder stall, selected by request type
//   cpuif_rd_ack/err/data   read completion
//   cpuif_wr_ack/err        write completion

module cpuif_host #(
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_is_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wr_data,
    input  logic [DATA_W-1:0] cmd_wr_biten,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rd_data,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              stray_ack,
    output logic              cpuif_req,
    output logic              cpuif_req_is_wr,
    output logic [ADDR_W-1:0] cpuif_addr,
    output logic [DATA_W-1:0] cpuif_wr_data,
    output logic [DATA_W-1:0] cpuif_wr_biten,
    input  logic              cpuif_req_stall_wr,
    input  logic              cpuif_req_stall_rd,
    input  logic              cpuif_rd_ack,
    input  logic              cpuif_rd_err,
    input  logic [DATA_W-1:0] cpuif_rd_data,
    input  logic              cpuif_wr_ack,
    input  logic              cpuif_wr_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_ACK,
        S_RSP
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_req;
    logic              r_is_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_wr_biten;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rd_data;
    logic              r_rsp_err;
    logic              r_rsp_timeout;
    logic              r_stray;

    logic              w_in_flight;
    logic              w_stall;
    logic              w_match_ack;
    logic              w_wrong_ack;
    logic              w_stray;
    logic              w_last_cycle;
    logic              w_ack_err;
    logic [DATA_W-1:0] w_ack_data;

    assign w_in_flight  = (r_state == S_REQ) || (r_state == S_WAIT_ACK);
    assign w_stall      = r_is_wr ? cpuif_req_stall_wr : cpuif_req_stall_rd;
    assign w_match_ack  = r_is_wr ? cpuif_wr_ack : cpuif_rd_ack;
    assign w_wrong_ack  = r_is_wr ? cpuif_rd_ack : cpuif_wr_ack;

    // In flight, only the wrong-type ack is stray; otherwise every ack is.
    assign w_stray      = w_in_flight ? w_wrong_ack : (cpuif_rd_ack | cpuif_wr_ack);

    // r_cnt counts completed REQ/WAIT_ACK cycles, so the current cycle is the
    // TIMEOUT-th one when r_cnt == TIMEOUT-1.
    assign w_last_cycle = (r_cnt == CNT_W'(TIMEOUT - 1));

    assign w_ack_err    = r_is_wr ? cpuif_wr_err : cpuif_rd_err;
    assign w_ack_data   = (r_is_wr || cpuif_rd_err) ? '0 : cpuif_rd_data;

    assign cmd_ready    = reset_n && (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_req         <= 1'b0;
            r_is_wr       <= 1'b0;
            r_addr        <= '0;
            r_wr_data     <= '0;
            r_wr_biten    <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rd_data <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_stray       <= 1'b0;
        end else begin
            r_stray <= w_stray;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_is_wr    <= cmd_is_wr;
                        r_addr     <= cmd_addr;
                        r_wr_data  <= cmd_is_wr ? cmd_wr_data : '0;
                        r_wr_biten <= cmd_is_wr ? cmd_wr_biten : '0;
                        r_req      <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ, S_WAIT_ACK: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_match_ack) begin
                        // An ack always wins over a coincident timeout.
                        r_req         <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rd_data <= w_ack_data;
                        r_rsp_err     <= w_ack_err;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= S_RSP;
                    end else if (w_last_cycle) begin
                        // Withdraw the request even if it is still stalled.
                        r_req         <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rd_data <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= S_RSP;
                    end else if ((r_state == S_REQ) && !w_stall) begin
                        r_req   <= 1'b0;
                        r_state <= S_WAIT_ACK;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid   <= 1'b0;
                        r_rsp_rd_data <= '0;
                        r_rsp_err     <= 1'b0;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_req       <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign cpuif_req       = r_req;
    assign cpuif_req_is_wr = r_is_wr;
    assign cpuif_addr      = r_addr;
    assign cpuif_wr_data   = r_wr_data;
    assign cpuif_wr_biten  = r_wr_biten;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rd_data     = r_rsp_rd_data;
    assign rsp_err         = r_rsp_err;
    assign rsp_timeout     = r_rsp_timeout;
    assign stray_ack       = r_stray;

endmodule

// File: tb/tb_cpuif_host.sv
// tb_cpuif_host
//   Directed and randomized transactions against cpuif_host. The expected
//   request window, response cycle and response contents come from the
//   transaction's stall count and ack delay using plain arithmetic.

module tb_cpuif_host;

    localparam int TO = 64;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_is_wr;
    logic [2:0]  cmd_addr;
    logic [15:0] cmd_wr_data;
    logic [15:0] cmd_wr_biten;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rd_data;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        stray_ack;
    logic        cpuif_req;
    logic        cpuif_req_is_wr;
    logic [2:0]  cpuif_addr;
    logic [15:0] cpuif_wr_data;
    logic [15:0] cpuif_wr_biten;
    logic        cpuif_req_stall_wr;
    logic        cpuif_req_stall_rd;
    logic        cpuif_rd_ack;
    logic        cpuif_rd_err;
    logic [15:0] cpuif_rd_data;
    logic        cpuif_wr_ack;
    logic        cpuif_wr_err;

    int n_assert = 0;
    int n_fail   = 0;

    cpuif_host #(
        .ADDR_W (3),
        .DATA_W (16),
        .TIMEOUT(TO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_is_wr         (cmd_is_wr),
        .cmd_addr          (cmd_addr),
        .cmd_wr_data       (cmd_wr_data),
        .cmd_wr_biten      (cmd_wr_biten),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_rd_data       (rsp_rd_data),
        .rsp_err           (rsp_err),
        .rsp_timeout       (rsp_timeout),
        .stray_ack         (stray_ack),
        .cpuif_req         (cpuif_req),
        .cpuif_req_is_wr   (cpuif_req_is_wr),
        .cpuif_addr        (cpuif_addr),
        .cpuif_wr_data     (cpuif_wr_data),
        .cpuif_wr_biten    (cpuif_wr_biten),
        .cpuif_req_stall_wr(cpuif_req_stall_wr),
        .cpuif_req_stall_rd(cpuif_req_stall_rd),
        .cpuif_rd_ack      (cpuif_rd_ack),
        .cpuif_rd_err      (cpuif_rd_err),
        .cpuif_rd_data     (cpuif_rd_data),
        .cpuif_wr_ack      (cpuif_wr_ack),
        .cpuif_wr_err      (cpuif_wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_req"},     cpuif_req, 0);
        chk({pfx, "_is_wr"},   cpuif_req_is_wr, 0);
        chk({pfx, "_addr"},    cpuif_addr, 0);
        chk({pfx, "_wdata"},   cpuif_wr_data, 0);
        chk({pfx, "_biten"},   cpuif_wr_biten, 0);
        chk({pfx, "_rvalid"},  rsp_valid, 0);
        chk({pfx, "_rdata"},   rsp_rd_data, 0);
        chk({pfx, "_rerr"},    rsp_err, 0);
        chk({pfx, "_rto"},     rsp_timeout, 0);
        chk({pfx, "_stray"},   stray_ack, 0);
    endtask

    // Responder-side inputs go idle; data/error lines carry noise that must
    // be ignored when no ack qualifies them.
    task automatic idle_responder();
        cpuif_req_stall_wr = 1'b0;
        cpuif_req_stall_rd = 1'b0;
        cpuif_rd_ack       = 1'b0;
        cpuif_wr_ack       = 1'b0;
        cpuif_rd_err       = 1'($urandom_range(0, 1));
        cpuif_wr_err       = 1'($urandom_range(0, 1));
        cpuif_rd_data      = 16'($urandom);
    endtask

    // stall: cycles the request is stalled before acceptance
    // dly:   0 = ack in the acceptance cycle, k = ack in the k-th wait cycle
    // bp:    cycles rsp_ready is held low once the response is valid
    // late:  backpressure cycle index carrying a late rd_ack (-1 = none)
    // wrong: inject a wrong-type ack in the first request cycle
    task automatic run_txn(input bit wr, input logic [2:0] a, input logic [15:0] d,
                           input logic [15:0] be, input int stall, input int dly,
                           input bit err, input logic [15:0] rdd, input int bp,
                           input int late, input bit wrong_in);
        int          n_ack;
        int          last;
        bit          to;
        bit          wrong;
        logic [15:0] e_data;
        logic        e_err;

        n_ack  = stall + 1 + dly;
        to     = (n_ack > TO);
        last   = to ? TO : n_ack;
        wrong  = wrong_in && (n_ack >= 2);
        e_err  = to || err;
        e_data = (wr || e_err) ? 16'h0000 : rdd;

        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid    = 1'b1;
        cmd_is_wr    = wr;
        cmd_addr     = a;
        cmd_wr_data  = d;
        cmd_wr_biten = be;
        tick();
        cmd_valid    = 1'b0;
        cmd_is_wr    = ~wr;
        cmd_addr     = 3'($urandom);
        cmd_wr_data  = 16'($urandom);
        cmd_wr_biten = 16'($urandom);

        for (int c = 1; c <= last; c++) begin
            chk("req_window", cpuif_req, (c <= stall + 1));
            if (c <= stall + 1) begin
                chk("req_is_wr", cpuif_req_is_wr, wr);
                chk("req_addr",  cpuif_addr, a);
                chk("req_wdata", cpuif_wr_data, wr ? d : 16'h0000);
                chk("req_biten", cpuif_wr_biten, wr ? be : 16'h0000);
            end
            chk("rsp_valid_busy", rsp_valid, 0);
            chk("cmd_ready_busy", cmd_ready, 0);
            chk("stray_busy", stray_ack, (wrong && c == 2));
            if (wr) begin
                cpuif_req_stall_wr = (c <= stall);
                cpuif_req_stall_rd = 1'($urandom_range(0, 1));
            end else begin
                cpuif_req_stall_rd = (c <= stall);
                cpuif_req_stall_wr = 1'($urandom_range(0, 1));
            end
            if (!to && c == n_ack) begin
                if (wr) begin
                    cpuif_wr_ack = 1'b1;
                    cpuif_wr_err = err;
                end else begin
                    cpuif_rd_ack  = 1'b1;
                    cpuif_rd_err  = err;
                    cpuif_rd_data = rdd;
                end
            end
            if (wrong && c == 1) begin
                if (wr) cpuif_rd_ack = 1'b1;
                else    cpuif_wr_ack = 1'b1;
            end
            tick();
            idle_responder();
        end

        for (int j = 0; j <= bp; j++) begin
            chk("rsp_valid",   rsp_valid, 1);
            chk("rsp_rd_data", rsp_rd_data, e_data);
            chk("rsp_err",     rsp_err, e_err);
            chk("rsp_timeout", rsp_timeout, to);
            chk("req_in_rsp",  cpuif_req, 0);
            chk("cmd_ready_rsp", cmd_ready, 0);
            chk("stray_rsp",   stray_ack, (j > 0 && late == j - 1));
            if (late == j) cpuif_rd_ack = 1'b1;
            rsp_ready = (j == bp);
            tick();
            idle_responder();
            rsp_ready = 1'b0;
        end
        chk("rsp_valid_done", rsp_valid, 0);
        chk("cmd_ready_done", cmd_ready, 1);
        chk("stray_done", stray_ack, (late == bp));
    endtask

    initial begin
        reset_n      = 1'b0;
        cmd_valid    = 1'b0;
        cmd_is_wr    = 1'b0;
        cmd_addr     = '0;
        cmd_wr_data  = '0;
        cmd_wr_biten = '0;
        rsp_ready    = 1'b0;
        idle_responder();

        // Reset state
        tick();
        tick();
        tick();
        chk_all_zero("reset");
        chk("reset_cmd_ready", cmd_ready, 0);
        reset_n = 1'b1;
        tick();
        chk("post_reset_cmd_ready", cmd_ready, 1);

        // Write, no stall, immediate ack: response 2 cycles after handshake
        run_txn(1'b1, 3'd1, 16'h00A5, 16'hFFFF, 0, 0, 1'b0, 16'h0000, 0, -1, 1'b0);
        // Read, 3 stall cycles, ack in third wait cycle: response 8 cycles on
        run_txn(1'b0, 3'd2, 16'h0000, 16'h0000, 3, 3, 1'b0, 16'h1234, 0, -1, 1'b0);
        // Response backpressure, then a second command right afterwards
        run_txn(1'b0, 3'd3, 16'h0000, 16'h0000, 0, 1, 1'b0, 16'hBEEF, 5, -1, 1'b0);
        run_txn(1'b1, 3'd4, 16'h5A5A, 16'h0F0F, 1, 0, 1'b0, 16'h0000, 0, -1, 1'b0);
        // Read error forces zero data; write error
        run_txn(1'b0, 3'd5, 16'h0000, 16'h0000, 0, 0, 1'b1, 16'hFFFF, 0, -1, 1'b0);
        run_txn(1'b1, 3'd6, 16'h1111, 16'h00FF, 0, 2, 1'b1, 16'h0000, 1, -1, 1'b0);
        // Wrong-type ack while waiting
        run_txn(1'b1, 3'd7, 16'hC3C3, 16'hFFFF, 0, 3, 1'b0, 16'h0000, 0, -1, 1'b1);
        // Ack on the last allowed cycle beats the timeout
        run_txn(1'b0, 3'd0, 16'h0000, 16'h0000, 10, TO - 11, 1'b0, 16'h7777, 0, -1, 1'b0);
        // Read timeout, late rd_ack 3 cycles after the response appears
        run_txn(1'b0, 3'd2, 16'h0000, 16'h0000, 0, 200, 1'b0, 16'hAAAA, 6, 3, 1'b0);
        // Write timeout with stall stuck high: request withdrawn at timeout
        run_txn(1'b1, 3'd3, 16'h9999, 16'hFFFF, 200, 0, 1'b0, 16'h0000, 0, -1, 1'b0);

        // Reset while waiting for the ack
        chk("rst_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_is_wr = 1'b0;
        cmd_addr  = 3'd5;
        tick();
        cmd_valid = 1'b0;
        chk("rst_req_issued", cpuif_req, 1);
        tick();
        chk("rst_in_wait", cpuif_req, 0);
        tick();
        reset_n = 1'b0;
        #1;
        chk("rst_cmd_ready_low", cmd_ready, 0);
        tick();
        chk_all_zero("midrst");
        reset_n      = 1'b1;
        cpuif_rd_ack = 1'b1;
        cpuif_rd_data = 16'h4321;
        tick();
        idle_responder();
        chk("rst_stray", stray_ack, 1);
        chk("rst_no_rsp", rsp_valid, 0);
        chk("rst_no_req", cpuif_req, 0);
        tick();
        chk("rst_stray_clear", stray_ack, 0);
        chk("rst_no_rsp2", rsp_valid, 0);
        run_txn(1'b0, 3'd5, 16'h0000, 16'h0000, 1, 1, 1'b0, 16'h8765, 0, -1, 1'b0);

        // Randomized transactions
        for (int i = 0; i < 30; i++) begin
            run_txn(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 3) == 0), 16'($urandom),
                    int'($urandom_range(0, 3)), -1, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
